dct_answer_packer: RTL and testbench
====================================

// Module: dct_answer_packer
// PURPOSE
//  Output stage directly downstream of dct_1d in the task_13 datapath.
//  - Buffers the 16-bit DCT coefficients of one packet and packs them pairwise into 32-bit answer words.
//  - Once the packet is closed, streams the words to the task manager with ready/last handshake and a byte count.
// PARAMETERS
//  DATA_WIDTH_IN   16   width of one DCT coefficient (i_data); must be <=16
//  READ_DATA_WIDTH 32   answer word width (fixed 32; two samples per word)
//  NUM_WORDS       256  sample buffer depth (samples, not answer words); power of 2
//  FLUSH_CYCLES    8    idle cycles after i_input_last before the packet is closed (>= dct_1d latency)
// PORTS
//  i_clk                   in   1   clock, all logic on rising edge
//  i_rst_n                 in   1   synchronous reset, active low
//  i_data                  in   DATA_WIDTH_IN  DCT coefficient
//  i_data_valid            in   1   i_data valid this cycle
//  i_input_last            in   1   one-cycle pulse: final input byte of packet accepted upstream
//  i_tmanager_ready        in   1   task manager accepts a word this cycle
//  o_tanswer_ready         out  1   o_tdata holds a valid answer word
//  o_tdata                 out  32  answer word
//  o_tanswer_data_last     out  1   current o_tdata is the final word of the packet
//  o_packet_size_in_bytes  out  12  byte count of the answer packet
//  o_overflow              out  1   sticky: samples dropped because the buffer was full
// BEHAVIOUR
//  - Reset (i_rst_n=0 at rising edge): all outputs 0; state IDLE; pointers, sample count, flush counter and overflow cleared.
//    Applies mid-packet or mid-send with no partial output afterwards.
//  - FSM states:
//    IDLE    -> COLLECT on first i_data_valid; that sample is stored.
//    COLLECT -> FLUSH on i_input_last; a valid sample in the same cycle is still stored.
//    FLUSH   -> SEND when FLUSH_CYCLES consecutive cycles pass without i_data_valid.
//               Any valid sample is stored and restarts the flush counter.
//    SEND    -> IDLE on the cycle the last word is accepted.
//  - i_input_last seen in IDLE (zero samples) goes straight to FLUSH. The packet is then one word 32'h0.
//  - Packing: sample 2k is sign-extended into [15:0] and sample 2k+1 into [31:16] of word k.
//    An odd count pads [31:16] with 0.
//  - Word count W = ceil(N/2); W=1 when N=0. o_packet_size_in_bytes = 4*W.
//    It is valid and stable throughout SEND and 0 outside SEND.
//  - Handshake: in SEND, o_tanswer_ready=1 and o_tdata valid while words remain.
//    A word transfers on a cycle with o_tanswer_ready & i_tmanager_ready.
//    The next word is presented the following cycle, so back-to-back transfers give 1 word/cycle.
//    o_tdata and last hold stable while i_tmanager_ready=0.
//  - First o_tanswer_ready rises at most 2 cycles after entering SEND. A read prefetch is allowed.
//  - o_tanswer_data_last=1 only together with o_tanswer_ready on word W-1.
//  - Full: after NUM_WORDS samples, further i_data_valid samples are dropped and o_overflow sets.
//    The packet is still sent with NUM_WORDS samples.
//  - i_data_valid or i_input_last during SEND are ignored and do not affect the packet in flight.
//  - Pointer wrap: the buffer is reset to empty on entering IDLE. No wrap-around across packets.
//  - o_overflow clears only on reset.
// TESTING
//  - Samples 1,2,3,4 then last, ready=1
//    -> words 32'h0002_0001, 32'h0004_0003; last on word 2; size=8.
//  - Samples 5,-1,7 (odd)
//    -> words 32'hFFFF_0005, 32'h0000_0007; size=8.
//  - i_input_last with no samples
//    -> one word 32'h0 with last=1; size=4.
//  - 4 samples, i_tmanager_ready toggling 1,0,0,1
//    -> word 0 accepted, word 1 held stable 2 cycles, then accepted with last.
//  - NUM_WORDS+3 samples
//    -> NUM_WORDS/2 words sent; o_overflow=1; size=2*NUM_WORDS (mod 4096 wrap must be noted for NUM_WORDS>=2048).
//  - Reset asserted mid-SEND after word 1 of 4
//    -> next cycle o_tanswer_ready=0, size=0; a new packet 9,10 then yields 32'h000A_0009.

Source files
------------

// File: rtl/dct_answer_packer_if.sv
// Bus bundle between dct_1d output, the answer packer and the task manager.
// Slave side is the packer; master side drives samples and accepts words.
interface dct_answer_packer_if #(
  parameter int DATA_WIDTH_IN = 16
);
  logic [DATA_WIDTH_IN-1:0] i_data;
  logic                     i_data_valid;
  logic                     i_input_last;
  logic                     i_tmanager_ready;
  logic                     o_tanswer_ready;
  logic [31:0]              o_tdata;
  logic                     o_tanswer_data_last;
  logic [11:0]              o_packet_size_in_bytes;
  logic                     o_overflow;

  modport slave (
    input  i_data,
    input  i_data_valid,
    input  i_input_last,
    input  i_tmanager_ready,
    output o_tanswer_ready,
    output o_tdata,
    output o_tanswer_data_last,
    output o_packet_size_in_bytes,
    output o_overflow
  );

  modport master (
    output i_data,
    output i_data_valid,
    output i_input_last,
    output i_tmanager_ready,
    input  o_tanswer_ready,
    input  o_tdata,
    input  o_tanswer_data_last,
    input  o_packet_size_in_bytes,
    input  o_overflow
  );
endinterface

// File: rtl/dct_answer_packer.sv
// Buffers one packet of DCT coefficients, packs sample pairs into
// 32-bit answer words and streams them out with ready/last.
module dct_answer_packer #(
  parameter int DATA_WIDTH_IN   = 16,
  parameter int READ_DATA_WIDTH = 32,
  parameter int NUM_WORDS       = 256,
  parameter int FLUSH_CYCLES    = 8
) (
  input logic                i_clk,
  input logic                i_rst_n,
  dct_answer_packer_if.slave bus
);
  localparam int AW  = $clog2(NUM_WORDS);
  localparam int CW  = AW + 1;
  localparam int WAW = AW - 1;
  localparam int FW  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, COLLECT, FLUSH, SEND
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              rd_q, rd_d;
  logic [FW-1:0]              fl_q, fl_d;
  logic                       ovf_q, ovf_d;
  logic [READ_DATA_WIDTH-1:0] tdata_q, tdata_d;

  logic [READ_DATA_WIDTH-1:0] mem_q [NUM_WORDS/2];

  logic [15:0]                s16;
  logic                       take, full, wr, send, is_last;
  logic [CW-1:0]              wcnt;
  logic [CW+1:0]              bytes;
  logic [WAW-1:0]             nidx;
  logic [READ_DATA_WIDTH-1:0] first_w, next_w;

  assign s16  = 16'($signed(bus.i_data));
  assign send = (state_q == SEND);
  assign take = bus.i_data_valid && !send;
  assign full = (cnt_q == CW'(NUM_WORDS));
  assign wr   = take && !full && i_rst_n;

  // An empty packet still answers with a single all-zero word.
  assign wcnt = (cnt_q == '0) ? CW'(1)
              : CW'((cnt_q + CW'(1)) >> 1);
  assign bytes   = {wcnt, 2'b00};
  assign is_last = (rd_q == wcnt - CW'(1));
  assign nidx    = rd_q[WAW-1:0] + WAW'(1);
  assign first_w = (cnt_q == '0) ? '0 : mem_q[0];
  assign next_w  = mem_q[nidx];

  // Even samples clear the upper half so an odd tail reads as zero-padded.
  always_ff @(posedge i_clk) begin
    if (wr) begin
      if (!cnt_q[0]) begin
        mem_q[cnt_q[AW-1:1]] <=
          {{(READ_DATA_WIDTH-16){1'b0}}, s16};
      end else begin
        mem_q[cnt_q[AW-1:1]][31:16] <= s16;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    fl_d    = fl_q;
    ovf_d   = ovf_q;
    tdata_d = tdata_q;
    if (take) begin
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (bus.i_input_last) begin
          state_d = FLUSH;
          fl_d    = '0;
        end else if (bus.i_data_valid) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.i_input_last) begin
          state_d = FLUSH;
          fl_d    = '0;
        end
      end
      FLUSH: begin
        if (bus.i_data_valid) begin
          fl_d = '0;
        end else if (fl_q == FW'(FLUSH_CYCLES - 1)) begin
          state_d = SEND;
          rd_d    = '0;
          tdata_d = first_w;
        end else begin
          fl_d = fl_q + FW'(1);
        end
      end
      SEND: begin
        if (bus.i_tmanager_ready) begin
          if (is_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            rd_d    = '0;
          end else begin
            rd_d    = rd_q + CW'(1);
            tdata_d = next_w;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      fl_q    <= '0;
      ovf_q   <= 1'b0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      fl_q    <= fl_d;
      ovf_q   <= ovf_d;
      tdata_q <= tdata_d;
    end
  end

  assign bus.o_tanswer_ready     = send;
  assign bus.o_tdata             = send ? tdata_q[31:0] : '0;
  assign bus.o_tanswer_data_last = send && is_last;
  assign bus.o_packet_size_in_bytes =
    send ? 12'(bytes) : '0;
  assign bus.o_overflow          = ovf_q;
endmodule

// File: tb/tb_dct_answer_packer.sv
// Randomized self-checking bench for dct_answer_packer against a
// queue-based packet model, plus directed corner packets.
module tb_dct_answer_packer;
  localparam int NW = 16;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   ovf_exp = 1'b0;

  logic [15:0] pkt [$];
  bit          rpat [$];
  logic [31:0] got [$];

  dct_answer_packer_if #(.DATA_WIDTH_IN(16)) bus ();

  dct_answer_packer #(
    .DATA_WIDTH_IN  (16),
    .READ_DATA_WIDTH(32),
    .NUM_WORDS      (NW),
    .FLUSH_CYCLES   (FL)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] d,
                     input bit l);
    bus.i_data       = d;
    bus.i_data_valid = v;
    bus.i_input_last = l;
    @(posedge clk);
    #1;
    bus.i_data_valid = 1'b0;
    bus.i_input_last = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_rdy"}, 32'(bus.o_tanswer_ready), 0);
    check({tag, "_last"}, 32'(bus.o_tanswer_data_last), 0);
    check({tag, "_size"}, 32'(bus.o_packet_size_in_bytes), 0);
    check({tag, "_data"}, bus.o_tdata, 0);
  endtask

  task automatic do_reset();
    bus.i_tmanager_ready = 1'b0;
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0);
    idle_checks("rst");
    ovf_exp = 1'b0;
    check("rst_ovf", 32'(bus.o_overflow), 0);
    cyc(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0);
  endtask

  // Drives pkt, closes it, then drains and compares every
  // presented word with the model until W words are taken.
  task automatic run_pkt(input bit lw, input int post,
                         input bit rnd, input int abort_k);
    logic [15:0] all [$];
    logic [31:0] exp_w [$];
    logic [15:0] lo, hi, d;
    logic [31:0] obs;
    int st, w, lat, k, guard;
    bit tr, lw_eff;
    all = pkt;
    got.delete();
    lw_eff = lw && (pkt.size() > 0);
    for (int i = 0; i < pkt.size(); i++) begin
      repeat ($urandom_range(0, 2)) cyc(1'b0, '0, 1'b0);
      cyc(1'b1, pkt[i], lw_eff && (i == pkt.size() - 1));
    end
    if (!lw_eff) cyc(1'b0, '0, 1'b1);
    for (int j = 0; j < post; j++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, '0, 1'b0);
      d = 16'($urandom);
      cyc(1'b1, d, 1'b0);
      all.push_back(d);
    end
    st = (all.size() > NW) ? NW : all.size();
    if (all.size() > NW) ovf_exp = 1'b1;
    w = (st == 0) ? 1 : (st + 1) / 2;
    for (int i = 0; i < w; i++) begin
      lo = (2 * i < st) ? all[2 * i] : 16'h0;
      hi = (2 * i + 1 < st) ? all[2 * i + 1] : 16'h0;
      exp_w.push_back({hi, lo});
    end
    check("pre_rdy", 32'(bus.o_tanswer_ready), 0);
    check("pre_size", 32'(bus.o_packet_size_in_bytes), 0);
    lat = 0;
    while (!bus.o_tanswer_ready && lat < 64) begin
      cyc(1'b0, '0, 1'b0);
      lat++;
    end
    check("latency", 32'(lat >= FL && lat <= FL + 2), 1);
    check("ovf", 32'(bus.o_overflow), 32'(ovf_exp));
    k = 0;
    guard = 0;
    while (k < w && k != abort_k && guard < 300) begin
      check("rdy", 32'(bus.o_tanswer_ready), 1);
      check("data", bus.o_tdata, exp_w[k]);
      check("last", 32'(bus.o_tanswer_data_last),
            32'(k == w - 1));
      check("size", 32'(bus.o_packet_size_in_bytes),
            32'(12'(4 * w)));
      obs = bus.o_tdata;
      if (rpat.size() > 0) tr = rpat.pop_front();
      else if (rnd)        tr = 1'($urandom_range(0, 1));
      else                 tr = 1'b1;
      bus.i_tmanager_ready = tr;
      cyc(1'($urandom_range(0, 1)), 16'($urandom),
          ($urandom_range(0, 3) == 0));
      if (tr) begin
        got.push_back(obs);
        k++;
      end
      guard++;
    end
    bus.i_tmanager_ready = 1'b0;
    if (abort_k < 0) begin
      check("words_sent", 32'(k), 32'(w));
      check("post_rdy", 32'(bus.o_tanswer_ready), 0);
      check("post_size", 32'(bus.o_packet_size_in_bytes), 0);
    end
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    bus.i_input_last = 1'b0;
    bus.i_tmanager_ready = 1'b0;
    cyc(1'b0, '0, 1'b0);
    idle_checks("init");
    check("init_ovf", 32'(bus.o_overflow), 0);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0);

    pkt = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_pkt(1'b0, 0, 1'b0, -1);
    check("t1_w0", got[0], 32'h0002_0001);
    check("t1_w1", got[1], 32'h0004_0003);

    pkt = '{16'd5, 16'hFFFF, 16'd7};
    run_pkt(1'b1, 0, 1'b0, -1);
    check("t2_w0", got[0], 32'hFFFF_0005);
    check("t2_w1", got[1], 32'h0000_0007);

    pkt.delete();
    run_pkt(1'b0, 0, 1'b0, -1);
    check("t3_n", 32'(got.size()), 1);
    check("t3_w0", got[0], 32'h0);

    pkt = '{16'd11, 16'd12, 16'd13, 16'd14};
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_pkt(1'b0, 0, 1'b0, -1);
    check("t4_w1", got[1], 32'h000E_000D);
    rpat.delete();

    for (int r = 0; r < 20; r++) begin
      pkt.delete();
      repeat ($urandom_range(0, NW + 4))
        pkt.push_back(16'($urandom));
      run_pkt(1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), -1);
    end

    pkt.delete();
    for (int i = 0; i < NW + 3; i++)
      pkt.push_back(16'(i * 3 + 1));
    run_pkt(1'b0, 0, 1'b1, -1);
    check("t5_n", 32'(got.size()), NW / 2);
    check("t5_ovf", 32'(bus.o_overflow), 1);

    pkt.delete();
    for (int i = 0; i < 8; i++) pkt.push_back(16'(i + 20));
    run_pkt(1'b0, 0, 1'b0, 1);
    do_reset();

    pkt = '{16'd9, 16'd10};
    run_pkt(1'b0, 0, 1'b0, -1);
    check("t6_w0", got[0], 32'h000A_0009);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
